gpio_sched: RTL and testbench

- PerInt master that owns one gpio peripheral.
- After reset it configures the IO directions and debounce, then reads a baseline input snapshot.
- It then services gpio interrupts (acknowledge, read, diff) and queues change events in a FIFO for a host.
- It also arbitrates host reconfiguration and output-write requests onto the single PerInt port.

---
 rtl/gpio_sched_pkg.sv | 17 +
 rtl/gpio_sched_if.sv | 14 +
 rtl/gpio_sched_fifo.sv | 46 ++++
 rtl/gpio_sched.sv | 203 ++++++++++++++++++++
 tb/tb_gpio_sched.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_sched_pkg.sv
// rtl/gpio_sched_pkg.sv - PerInt op encodings, gpio command codes and scheduler states
package gpio_sched_pkg;

   localparam logic [1:0] PINOOP = 2'b00;
   localparam logic [1:0] PIWROP = 2'b01;
   localparam logic [1:0] PIRDOP = 2'b10;
   localparam logic [1:0] PIRWOP = 2'b11;

   localparam logic CMDCONFIGUREIO = 1'b0;
   localparam logic CMDSETDEBOUNCE = 1'b1;

   typedef enum logic [3:0] {
      S_CFG, S_CFGR, S_DBN, S_DBNR, S_BRD, S_BRDR,
      S_IDLE, S_ACK, S_IRD, S_IRDR, S_WR
   } state_t;

endpackage

// File: rtl/gpio_sched_if.sv
// rtl/gpio_sched_if.sv - PerInt bus between the scheduler (master) and the gpio peripheral (slave)
interface gpio_sched_if #(
   parameter int ARCHBITSZ = 32
) ();

   logic [1:0]           m_op_o;
   logic [ARCHBITSZ-1:0] m_data_o;
   logic [ARCHBITSZ-1:0] m_data_i;
   logic                 m_rdy_i;

   modport master (output m_op_o, output m_data_o, input m_data_i, input m_rdy_i);
   modport slave  (input m_op_o, input m_data_o, output m_data_i, output m_rdy_i);

endinterface

// File: rtl/gpio_sched_fifo.sv
// rtl/gpio_sched_fifo.sv - synchronous event FIFO; a push into a full FIFO succeeds only with a same-cycle pop
module gpio_sched_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit tells full from empty when the index bits match.
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
            r_wptr                <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpio_sched.sv
// rtl/gpio_sched.sv - PerInt master: gpio init, interrupt service into an event FIFO, host cfg/write arbitration
// Define GPIO_SCHED_TSTAMP_EN to add ev_ts_o, a 16-bit cycle timestamp per event.
module gpio_sched
   import gpio_sched_pkg::*;
#(
   parameter int                   ARCHBITSZ = 32,
   parameter int                   IOCOUNT   = 8,
   parameter logic [IOCOUNT-1:0]   INITT     = '0,
   parameter logic [ARCHBITSZ-2:0] INITDBNC  = '0,
   parameter int                   EVDEPTH   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   gpio_sched_if.master         m,
   input  logic                 intrqst_i,
   output logic                 intrdy_o,
   input  logic                 cfg_vld_i,
   input  logic [IOCOUNT-1:0]   cfg_t_i,
   input  logic [ARCHBITSZ-2:0] cfg_dbnc_i,
   output logic                 cfg_rdy_o,
   input  logic                 out_vld_i,
   input  logic [IOCOUNT-1:0]   out_data_i,
   output logic                 out_rdy_o,
   output logic                 ev_vld_o,
   output logic [IOCOUNT-1:0]   ev_data_o,
   output logic [IOCOUNT-1:0]   ev_chg_o,
   input  logic                 ev_rdy_i,
   output logic                 ev_ovf_o,
`ifdef GPIO_SCHED_TSTAMP_EN
   output logic [15:0]          ev_ts_o,
`endif
   output logic [ARCHBITSZ-1:0] iocount_o,
   output logic [ARCHBITSZ-1:0] clkfreq_o,
   output logic                 busy_o
);

`ifdef GPIO_SCHED_TSTAMP_EN
   localparam int FW = 2*IOCOUNT + 16;
   logic [15:0] r_ts;
`else
   localparam int FW = 2*IOCOUNT;
`endif

   state_t               r_state, w_state_nxt, w_after;
   logic [1:0]           r_op, w_op_nxt, w_iss_op;
   logic [ARCHBITSZ-1:0] r_data, w_data_nxt, w_iss_data, w_wdata;
   logic [IOCOUNT-1:0]   r_t, w_t_nxt, r_last, w_last_nxt, w_chg;
   logic [ARCHBITSZ-2:0] r_dbnc, w_dbnc_nxt, w_arg_t;
   logic [ARCHBITSZ-1:0] r_iocount, w_iocount_nxt, r_clkfreq, w_clkfreq_nxt;
   logic                 r_cfg_rdy, w_cfg_rdy_nxt, r_ovf, w_ovf_nxt;
   logic                 w_push, w_full, w_empty;
   logic [FW-1:0]        w_fifo_in, w_head;

   always_comb begin
      w_state_nxt   = r_state;
      w_op_nxt      = r_op;
      w_data_nxt    = r_data;
      w_t_nxt       = r_t;
      w_dbnc_nxt    = r_dbnc;
      w_last_nxt    = r_last;
      w_iocount_nxt = r_iocount;
      w_clkfreq_nxt = r_clkfreq;
      w_cfg_rdy_nxt = 1'b0;
      w_ovf_nxt     = r_ovf;
      w_push        = 1'b0;
      w_chg         = m.m_data_i[IOCOUNT-1:0] ^ r_last;
      w_arg_t       = '0;
      w_arg_t[IOCOUNT-1:0] = r_t;
      w_wdata       = '0;
      w_wdata[IOCOUNT-1:0] = out_data_i;
      w_iss_op      = PIRDOP;
      w_iss_data    = r_data;
      w_after       = S_IDLE;

      // Op issued by each bus state and the state that follows its acceptance.
      case (r_state)
         S_CFG:   begin w_iss_op = PIRWOP; w_iss_data = {CMDCONFIGUREIO, w_arg_t}; w_after = S_CFGR; end
         S_DBN:   begin w_iss_op = PIRWOP; w_iss_data = {CMDSETDEBOUNCE, r_dbnc};  w_after = S_DBNR; end
         S_BRD:   w_after = S_BRDR;
         S_IRD:   w_after = S_IRDR;
         S_WR:    w_iss_op = PIWROP;
         default: ;
      endcase

      case (r_state)
         S_CFG, S_DBN, S_BRD, S_IRD, S_WR: begin
            if (r_op == PINOOP) begin
               w_op_nxt   = w_iss_op;
               w_data_nxt = w_iss_data;
            end else if (m.m_rdy_i) begin
               w_op_nxt    = PINOOP;
               w_state_nxt = w_after;
            end
         end
         S_CFGR: begin
            w_iocount_nxt = m.m_data_i;
            w_state_nxt   = S_DBN;
         end
         S_DBNR: begin
            w_clkfreq_nxt = m.m_data_i;
            w_state_nxt   = S_BRD;
         end
         S_BRDR: begin
            w_last_nxt  = m.m_data_i[IOCOUNT-1:0];
            w_state_nxt = S_IDLE;
         end
         S_ACK: w_state_nxt = S_IRD;
         S_IRDR: begin
            w_last_nxt  = m.m_data_i[IOCOUNT-1:0];
            w_push      = (w_chg != '0);
            w_state_nxt = S_IDLE;
            if (w_push && w_full && !ev_rdy_i) begin
               w_ovf_nxt = 1'b1;
            end
         end
         S_IDLE: begin
            if (cfg_vld_i) begin
               w_t_nxt       = cfg_t_i;
               w_dbnc_nxt    = cfg_dbnc_i;
               w_cfg_rdy_nxt = 1'b1;
               w_ovf_nxt     = 1'b0;
               w_state_nxt   = S_CFG;
            end else if (intrqst_i) begin
               w_state_nxt = S_ACK;
            end else if (out_vld_i) begin
               // Capture the write value while the host still presents it.
               w_op_nxt    = PIWROP;
               w_data_nxt  = w_wdata;
               w_state_nxt = S_WR;
            end
         end
         default: w_state_nxt = S_CFG;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state   <= S_CFG;
         r_op      <= PINOOP;
         r_data    <= '0;
         r_t       <= INITT;
         r_dbnc    <= INITDBNC;
         r_last    <= '0;
         r_iocount <= '0;
         r_clkfreq <= '0;
         r_cfg_rdy <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_op      <= w_op_nxt;
         r_data    <= w_data_nxt;
         r_t       <= w_t_nxt;
         r_dbnc    <= w_dbnc_nxt;
         r_last    <= w_last_nxt;
         r_iocount <= w_iocount_nxt;
         r_clkfreq <= w_clkfreq_nxt;
         r_cfg_rdy <= w_cfg_rdy_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

`ifdef GPIO_SCHED_TSTAMP_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + 16'd1;
      end
   end
   assign w_fifo_in = {r_ts, m.m_data_i[IOCOUNT-1:0], w_chg};
   assign ev_ts_o   = w_head[FW-1:2*IOCOUNT];
`else
   assign w_fifo_in = {m.m_data_i[IOCOUNT-1:0], w_chg};
`endif

   gpio_sched_fifo #(
      .WIDTH (FW),
      .DEPTH (EVDEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_push      (w_push),
      .i_push_data (w_fifo_in),
      .i_pop       (ev_rdy_i),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign m.m_op_o   = r_op;
   assign m.m_data_o = r_data;
   assign intrdy_o   = (r_state != S_ACK);
   assign cfg_rdy_o  = r_cfg_rdy;
   assign out_rdy_o  = (r_state == S_WR) && (r_op == PIWROP) && m.m_rdy_i;
   assign ev_vld_o   = !w_empty;
   assign ev_data_o  = w_head[2*IOCOUNT-1:IOCOUNT];
   assign ev_chg_o   = w_head[IOCOUNT-1:0];
   assign ev_ovf_o   = r_ovf;
   assign iocount_o  = r_iocount;
   assign clkfreq_o  = r_clkfreq;
   assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpio_sched.sv
// tb/tb_gpio_sched.sv - directed self-checking bench for gpio_sched with a PerInt slave responder
module tb_gpio_sched;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        intrqst_i = 1'b0, intrdy_o;
   logic        cfg_vld_i = 1'b0, cfg_rdy_o;
   logic [7:0]  cfg_t_i = '0;
   logic [30:0] cfg_dbnc_i = '0;
   logic        out_vld_i = 1'b0, out_rdy_o;
   logic [7:0]  out_data_i = '0;
   logic        ev_vld_o, ev_rdy_i = 1'b0, ev_ovf_o, busy_o;
   logic [7:0]  ev_data_o, ev_chg_o;
   logic [31:0] iocount_o, clkfreq_o;
`ifdef GPIO_SCHED_TSTAMP_EN
   logic [15:0] ev_ts_o;
`endif

   int checks = 0;
   int errors = 0;

   logic [1:0]  op_log[$];
   logic [31:0] dat_log[$];
   logic [31:0] rsp_q[$];

   always #5 clk = ~clk;

   gpio_sched_if #(.ARCHBITSZ(32)) bus ();

   gpio_sched #(
      .ARCHBITSZ (32),
      .IOCOUNT   (8),
      .INITT     (8'h0F),
      .INITDBNC  (31'd5),
      .EVDEPTH   (4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .m          (bus),
      .intrqst_i  (intrqst_i),
      .intrdy_o   (intrdy_o),
      .cfg_vld_i  (cfg_vld_i),
      .cfg_t_i    (cfg_t_i),
      .cfg_dbnc_i (cfg_dbnc_i),
      .cfg_rdy_o  (cfg_rdy_o),
      .out_vld_i  (out_vld_i),
      .out_data_i (out_data_i),
      .out_rdy_o  (out_rdy_o),
      .ev_vld_o   (ev_vld_o),
      .ev_data_o  (ev_data_o),
      .ev_chg_o   (ev_chg_o),
      .ev_rdy_i   (ev_rdy_i),
      .ev_ovf_o   (ev_ovf_o),
`ifdef GPIO_SCHED_TSTAMP_EN
      .ev_ts_o    (ev_ts_o),
`endif
      .iocount_o  (iocount_o),
      .clkfreq_o  (clkfreq_o),
      .busy_o     (busy_o)
   );

   // Slave: logs accepted ops, presents read data through the sampling cycle, then garbage.
   initial begin
      int hold;
      hold = 0;
      bus.m_data_i = 32'hDEADBEEF;
      bus.m_rdy_i  = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         if (bus.m_op_o != 2'b00 && bus.m_rdy_i) begin
            op_log.push_back(bus.m_op_o);
            dat_log.push_back(bus.m_data_o);
            if (bus.m_op_o[1]) begin
               bus.m_data_i = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
               hold = 2;
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) bus.m_data_i = 32'hDEADBEEF;
         end
      end
   end

   function automatic logic [1:0] get_op(input int i);
      return (i < op_log.size()) ? op_log[i] : 2'bxx;
   endfunction

   function automatic logic [31:0] get_dat(input int i);
      return (i < dat_log.size()) ? dat_log[i] : 32'hxxxxxxxx;
   endfunction

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_irq(input logic [31:0] d, output int lows, output bit ok);
      rsp_q.push_back(d);
      lows = 0;
      ok   = 1'b0;
      @(negedge clk);
      intrqst_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!intrdy_o) begin lows++; intrqst_i = 1'b0; end
         if (!intrqst_i && !busy_o) begin ok = 1'b1; break; end
      end
      intrqst_i = 1'b0;
   endtask

   task automatic do_cfg(input logic [7:0] t, input logic [30:0] db, input logic [31:0] r0, r1, r2,
                         output int pulses, output bit ok);
      rsp_q.push_back(r0); rsp_q.push_back(r1); rsp_q.push_back(r2);
      pulses = 0;
      ok     = 1'b0;
      @(negedge clk);
      cfg_t_i = t; cfg_dbnc_i = db; cfg_vld_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cfg_rdy_o) begin pulses++; cfg_vld_i = 1'b0; end
         if (!cfg_vld_i && !busy_o) begin ok = 1'b1; break; end
      end
      cfg_vld_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.m_op_o !== 2'b00) begin errors++; $display("FAIL reset_op: got %h expected 0", bus.m_op_o); end
      checks++; if (bus.m_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.m_data_o); end
      checks++; if (intrdy_o !== 1'b1) begin errors++; $display("FAIL reset_intrdy: got %b expected 1", intrdy_o); end
      checks++; if (cfg_rdy_o !== 1'b0 || out_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b%b expected 00", cfg_rdy_o, out_rdy_o); end
      checks++; if (ev_vld_o !== 1'b0 || ev_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ev: got %b%b expected 00", ev_vld_o, ev_ovf_o); end
      checks++; if (iocount_o !== 32'h0 || clkfreq_o !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h %h expected 0 0", iocount_o, clkfreq_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_o); end
   endtask

   task automatic test_init();
      bit ok;
      op_log.delete(); dat_log.delete(); rsp_q.delete();
      rsp_q.push_back(32'h8); rsp_q.push_back(32'h05F5E100); rsp_q.push_back(32'h1);
      @(negedge clk);
      rst_i = 1'b1;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL init_idle: busy_o still %b after budget, expected 0", busy_o); end
      checks++; if (op_log.size() !== 3) begin errors++; $display("FAIL init_count: got %0d ops expected 3", op_log.size()); end
      checks++; if (get_op(0) !== 2'b11 || get_dat(0) !== 32'h0000000F) begin errors++; $display("FAIL init_op0: got %b %h expected 11 0000000f", get_op(0), get_dat(0)); end
      checks++; if (get_op(1) !== 2'b11 || get_dat(1) !== 32'h80000005) begin errors++; $display("FAIL init_op1: got %b %h expected 11 80000005", get_op(1), get_dat(1)); end
      checks++; if (get_op(2) !== 2'b10) begin errors++; $display("FAIL init_op2: got %b expected 10", get_op(2)); end
      checks++; if (iocount_o !== 32'h8) begin errors++; $display("FAIL init_iocount: got %h expected 8", iocount_o); end
      checks++; if (clkfreq_o !== 32'h05F5E100) begin errors++; $display("FAIL init_clkfreq: got %h expected 05f5e100", clkfreq_o); end
      checks++; if (ev_vld_o !== 1'b0) begin errors++; $display("FAIL init_noev: got %b expected 0", ev_vld_o); end
   endtask

   task automatic test_irq();
      int lows;
      bit ok;
      op_log.delete(); dat_log.delete();
      do_irq(32'h05, lows, ok);
      checks++; if (!ok) begin errors++; $display("FAIL irq_done: service did not return to idle"); end
      checks++; if (lows !== 1) begin errors++; $display("FAIL irq_ack_len: got %0d low cycles expected 1", lows); end
      checks++; if (op_log.size() !== 1 || get_op(0) !== 2'b10) begin errors++; $display("FAIL irq_rd: got %0d ops first %b expected 1 op 10", op_log.size(), get_op(0)); end
      checks++; if (ev_vld_o !== 1'b1) begin errors++; $display("FAIL irq_ev_vld: got %b expected 1", ev_vld_o); end
      checks++; if (ev_data_o !== 8'h05 || ev_chg_o !== 8'h04) begin errors++; $display("FAIL irq_ev: got %h/%h expected 05/04", ev_data_o, ev_chg_o); end
      ev_rdy_i = 1'b1;
      @(negedge clk);
      ev_rdy_i = 1'b0;
      checks++; if (ev_vld_o !== 1'b0) begin errors++; $display("FAIL irq_pop: got ev_vld %b expected 0", ev_vld_o); end
   endtask

   task automatic test_overflow();
      logic [7:0] d[5]   = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      logic [7:0] chg[4] = '{8'h03, 8'h01, 8'h0F, 8'h01};
      int lows, pulses;
      bit ok;
      for (int i = 0; i < 5; i++) begin
         do_irq({24'h0, d[i]}, lows, ok);
      end
      checks++; if (ev_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ev_ovf_o); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ev_vld_o !== 1'b1 || ev_data_o !== d[i] || ev_chg_o !== chg[i]) begin
            errors++; $display("FAIL ovf_ev%0d: got vld %b %h/%h expected 1 %h/%h", i, ev_vld_o, ev_data_o, ev_chg_o, d[i], chg[i]);
         end
         ev_rdy_i = 1'b1;
         @(negedge clk);
         ev_rdy_i = 1'b0;
      end
      checks++; if (ev_vld_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: got ev_vld %b expected 0", ev_vld_o); end
      op_log.delete(); dat_log.delete();
      do_cfg(8'h3C, 31'd7, 32'h8, 32'd1234, 32'h0A, pulses, ok);
      checks++; if (!ok || pulses !== 1) begin errors++; $display("FAIL ovf_cfg: got ok %b pulses %0d expected 1 1", ok, pulses); end
      checks++; if (ev_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ev_ovf_o); end
      checks++; if (get_dat(0) !== 32'h0000003C || get_dat(1) !== 32'h80000007 || get_op(2) !== 2'b10) begin
         errors++; $display("FAIL ovf_cfg_ops: got %h %h %b expected 0000003c 80000007 10", get_dat(0), get_dat(1), get_op(2));
      end
      checks++; if (clkfreq_o !== 32'd1234 || ev_vld_o !== 1'b0) begin errors++; $display("FAIL ovf_cfg_state: got %0d %b expected 1234 0", clkfreq_o, ev_vld_o); end
   endtask

   task automatic test_priority();
      int cp, ap, wp;
      bit ok;
      cp = 0; ap = 0; wp = 0; ok = 1'b0;
      op_log.delete(); dat_log.delete(); rsp_q.delete();
      rsp_q.push_back(32'h8); rsp_q.push_back(32'd99); rsp_q.push_back(32'h0A); rsp_q.push_back(32'h0B);
      @(negedge clk);
      cfg_t_i = 8'h33; cfg_dbnc_i = 31'd9; out_data_i = 8'hA5;
      cfg_vld_i = 1'b1; intrqst_i = 1'b1; out_vld_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cfg_rdy_o) begin cp++; cfg_vld_i = 1'b0; end
         if (!intrdy_o) begin ap++; intrqst_i = 1'b0; end
         if (out_rdy_o) begin wp++; out_vld_i = 1'b0; end
         if (!cfg_vld_i && !intrqst_i && !out_vld_i && !busy_o) begin ok = 1'b1; break; end
      end
      cfg_vld_i = 1'b0; intrqst_i = 1'b0; out_vld_i = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL prio_done: requests not all serviced"); end
      checks++; if (cp !== 1 || ap !== 1 || wp !== 1) begin errors++; $display("FAIL prio_pulses: got cfg %0d ack %0d wr %0d expected 1 1 1", cp, ap, wp); end
      checks++; if (op_log.size() !== 5) begin errors++; $display("FAIL prio_count: got %0d ops expected 5", op_log.size()); end
      checks++; if (get_op(0) !== 2'b11 || get_dat(0) !== 32'h00000033 || get_op(1) !== 2'b11 || get_dat(1) !== 32'h80000009) begin
         errors++; $display("FAIL prio_cfg_first: got %b %h %b %h expected 11 00000033 11 80000009", get_op(0), get_dat(0), get_op(1), get_dat(1));
      end
      checks++; if (get_op(2) !== 2'b10 || get_op(3) !== 2'b10) begin errors++; $display("FAIL prio_reads: got %b %b expected 10 10", get_op(2), get_op(3)); end
      checks++; if (get_op(4) !== 2'b01 || get_dat(4) !== 32'h000000A5) begin errors++; $display("FAIL prio_wr_last: got %b %h expected 01 000000a5", get_op(4), get_dat(4)); end
      checks++; if (ev_vld_o !== 1'b1 || ev_data_o !== 8'h0B || ev_chg_o !== 8'h01) begin
         errors++; $display("FAIL prio_ev: got %b %h/%h expected 1 0b/01", ev_vld_o, ev_data_o, ev_chg_o);
      end
      ev_rdy_i = 1'b1;
      @(negedge clk);
      ev_rdy_i = 1'b0;
   endtask

   task automatic test_wr_stall();
      op_log.delete(); dat_log.delete();
      @(negedge clk);
      bus.m_rdy_i = 1'b0; out_data_i = 8'h3C; out_vld_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_vld_i = 1'b0;
         checks++;
         if (bus.m_op_o !== 2'b01 || bus.m_data_o !== 32'h0000003C || out_rdy_o !== 1'b0) begin
            errors++; $display("FAIL stall_c%0d: got op %b data %h rdy %b expected 01 0000003c 0", i, bus.m_op_o, bus.m_data_o, out_rdy_o);
         end
      end
      bus.m_rdy_i = 1'b1;
      #1;
      checks++; if (out_rdy_o !== 1'b1 || bus.m_op_o !== 2'b01) begin errors++; $display("FAIL stall_accept: got rdy %b op %b expected 1 01", out_rdy_o, bus.m_op_o); end
      @(negedge clk);
      checks++; if (bus.m_op_o !== 2'b00 || out_rdy_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL stall_after: got op %b rdy %b busy %b expected 00 0 0", bus.m_op_o, out_rdy_o, busy_o);
      end
      checks++; if (op_log.size() !== 1 || get_dat(0) !== 32'h0000003C) begin errors++; $display("FAIL stall_once: got %0d ops data %h expected 1 0000003c", op_log.size(), get_dat(0)); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      op_log.delete(); dat_log.delete(); rsp_q.delete();
      rsp_q.push_back(32'h77);
      @(negedge clk);
      bus.m_rdy_i = 1'b0; intrqst_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!intrdy_o) intrqst_i = 1'b0;
         if (!intrqst_i && bus.m_op_o == 2'b10) begin ok = 1'b1; break; end
      end
      intrqst_i = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL mid_reach_rd: RD op not presented"); end
      rst_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.m_op_o !== 2'b00 || intrdy_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got op %b intrdy %b busy %b expected 00 1 1", bus.m_op_o, intrdy_o, busy_o);
      end
      checks++; if (iocount_o !== 32'h0 || clkfreq_o !== 32'h0 || ev_vld_o !== 1'b0) begin
         errors++; $display("FAIL mid_regs: got %h %h %b expected 0 0 0", iocount_o, clkfreq_o, ev_vld_o);
      end
      rsp_q.delete(); op_log.delete(); dat_log.delete();
      rsp_q.push_back(32'h8); rsp_q.push_back(32'd77); rsp_q.push_back(32'h20);
      bus.m_rdy_i = 1'b1;
      rst_i = 1'b1;
      wait_idle(ok);
      checks++; if (!ok || op_log.size() !== 3) begin errors++; $display("FAIL mid_reinit: got ok %b ops %0d expected 1 3", ok, op_log.size()); end
      checks++; if (get_dat(0) !== 32'h0000000F || get_dat(1) !== 32'h80000005 || get_op(2) !== 2'b10) begin
         errors++; $display("FAIL mid_seq: got %h %h %b expected 0000000f 80000005 10", get_dat(0), get_dat(1), get_op(2));
      end
      checks++; if (clkfreq_o !== 32'd77 || ev_vld_o !== 1'b0) begin errors++; $display("FAIL mid_state: got %0d %b expected 77 0", clkfreq_o, ev_vld_o); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_irq();
      test_overflow();
      test_priority();
      test_wr_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
